multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter LOAD, 7'd3, load opcode.
REQ-002 SHALL have parameter STORE, 7'd35, store opcode.
REQ-003 SHALL have parameter REG, 7'd51, R-type ALU opcode.
REQ-004 SHALL have parameter I_AL, 7'd19, I-type ALU opcode.
REQ-005 SHALL have parameter BRANCH, 7'd99, branch opcode.
REQ-006 SHALL have parameter JAL, 7'd111, jump-and-link opcode.
REQ-007 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port Op, input, 7, opcode from instruction register bits [6:0].
REQ-010 SHALL have port Zero, input, 1, ALU zero flag.
REQ-011 SHALL have port MemReady, input, 1, memory completion (MEM_WAIT_EN only).
REQ-012 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Branch, IllegalOp, 1 bit each.
REQ-013 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB and ALUOp, 2 bits each, and ImmSrc, 3 bits.
REQ-014 SHALL have output State, 4 bits, current FSM state for debug.

Function
REQ-015 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL_S=9, BEQ=10.
REQ-016 SHALL use transitions FETCH->DECODE; DECODE->MEMADR (LOAD/STORE), EXECUTER (REG), EXECUTEI (I_AL), JAL_S (JAL), BEQ (BRANCH), FETCH (other); MEMADR->MEMREAD (LOAD) or MEMWRITE (STORE); MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL_S->ALUWB; MEMWB/MEMWRITE/ALUWB/BEQ->FETCH.
REQ-017 SHALL assert IllegalOp for exactly the DECODE cycle when Op matches no parameter, and write no state.
REQ-018 SHALL drive in FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PC update.
REQ-019 SHALL drive in DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
REQ-020 SHALL drive in MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-021 SHALL drive ResultSrc=00 and AdrSrc=1 in MEMREAD, and additionally MemWrite=1 in MEMWRITE.
REQ-022 SHALL drive in MEMWB: ResultSrc=01, RegWrite=1; in ALUWB: ResultSrc=00, RegWrite=1.
REQ-023 SHALL drive ALUSrcA=10 and ALUOp=10 in EXECUTER (ALUSrcB=00) and in EXECUTEI (ALUSrcB=01).
REQ-024 SHALL drive in JAL_S: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PC update.
REQ-025 SHALL drive in BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-026 SHALL drive every output not listed for a state as 0.
REQ-027 SHALL compute PCWrite = PC update OR (Branch AND Zero), combinationally, in the same cycle.
REQ-028 SHALL decode ImmSrc combinationally from Op: LOAD/I_AL 000, STORE 001, BRANCH 010, JAL 100, other 000.
REQ-029 SHALL produce these latencies without wait states: LOAD 5, STORE 4, REG 4, I_AL 4, JAL 4, BRANCH 3, illegal 2 cycles.

Reset
REQ-030 SHALL force State to FETCH immediately and asynchronously when rst_n=0, regardless of clk.
REQ-031 SHALL hold PCWrite, IRWrite, RegWrite, MemWrite and IllegalOp at 0 while rst_n=0.
REQ-032 SHALL perform its first FETCH on the first rising clk edge after rst_n deasserts.
REQ-033 SHALL abandon any in-flight instruction when reset asserts mid-sequence, with no write strobe escaping.

Configuration
REQ-034 SHALL gate memory wait states with macro MULTICYCLE_MEM_WAIT_EN.
REQ-035 SHALL, when MULTICYCLE_MEM_WAIT_EN is defined, hold FETCH, MEMREAD and MEMWRITE while MemReady=0, with IRWrite, PC update and MemWrite asserted only in the MemReady=1 cycle.
REQ-036 SHALL, when MULTICYCLE_MEM_WAIT_EN is undefined, omit the MemReady port and treat every state as single-cycle.

Verification
REQ-037 SHALL cover LOAD (Op=7'd3): State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; ImmSrc=000.
REQ-038 SHALL cover BRANCH (Op=7'd99): with Zero=1, PCWrite=1 in state 10; with Zero=0, PCWrite=0; 3 cycles back to FETCH.
REQ-039 SHALL cover STORE (Op=7'd35): sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle; RegWrite stays 0.
REQ-040 SHALL cover illegal Op=7'd0: IllegalOp=1 for one cycle in DECODE, then FETCH; no RegWrite or MemWrite.
REQ-041 SHALL cover rst_n pulsed low during MEMREAD: State=0 asynchronously; all strobes 0 until the next edge.
REQ-042 SHALL cover, with MULTICYCLE_MEM_WAIT_EN defined, MemReady=0 for 3 cycles in FETCH: State holds 0 and IRWrite=0, then IRWrite=1 for exactly one cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle processor main control FSM (Moore)
// Memory wait states are enabled by defining MULTICYCLE_MEM_WAIT_EN (adds MemReady).
module multicycle_ctrl #(
   parameter logic [6:0] LOAD   = 7'd3,
   parameter logic [6:0] STORE  = 7'd35,
   parameter logic [6:0] REG    = 7'd51,
   parameter logic [6:0] I_AL   = 7'd19,
   parameter logic [6:0] BRANCH = 7'd99,
   parameter logic [6:0] JAL    = 7'd111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] Op,
   input  logic       Zero,
`ifdef MULTICYCLE_MEM_WAIT_EN
   input  logic       MemReady,
`endif
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       Branch,
   output logic       IllegalOp,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL_S    = 4'd9,
      BEQ      = 4'd10
   } state_t;

   state_t state_q, state_d;
   logic   mem_rdy;
   logic   pc_upd, ir_wr, reg_wr, mem_wr, illegal;

`ifdef MULTICYCLE_MEM_WAIT_EN
   assign mem_rdy = MemReady;
`else
   assign mem_rdy = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      pc_upd    = 1'b0;
      ir_wr     = 1'b0;
      reg_wr    = 1'b0;
      mem_wr    = 1'b0;
      illegal   = 1'b0;
      AdrSrc    = 1'b0;
      Branch    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      case (state_q)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (mem_rdy) begin
               ir_wr   = 1'b1;
               pc_upd  = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            if (Op == LOAD || Op == STORE) state_d = MEMADR;
            else if (Op == REG)            state_d = EXECUTER;
            else if (Op == I_AL)           state_d = EXECUTEI;
            else if (Op == JAL)            state_d = JAL_S;
            else if (Op == BRANCH)         state_d = BEQ;
            else begin
               illegal = 1'b1;
               state_d = FETCH;
            end
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (Op == LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_rdy) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_wr    = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            if (mem_rdy) begin
               mem_wr  = 1'b1;
               state_d = FETCH;
            end
         end
         EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         ALUWB: begin
            reg_wr  = 1'b1;
            state_d = FETCH;
         end
         JAL_S: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pc_upd  = 1'b1;
            state_d = ALUWB;
         end
         BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            Branch  = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      ImmSrc = 3'b000;
      if (Op == STORE)       ImmSrc = 3'b001;
      else if (Op == BRANCH) ImmSrc = 3'b010;
      else if (Op == JAL)    ImmSrc = 3'b100;
   end

   // Reset forces FETCH, whose strobes would otherwise be live; mask them while rst_n is low.
   assign PCWrite   = rst_n & (pc_upd | (Branch & Zero));
   assign IRWrite   = rst_n & ir_wr;
   assign RegWrite  = rst_n & reg_wr;
   assign MemWrite  = rst_n & mem_wr;
   assign IllegalOp = rst_n & illegal;
   assign State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] Op;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Branch, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;
   logic [3:0] State;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [21:0] v;
      int          op;
      int          step;
   } exp_t;
   exp_t exp_q[$];

   multicycle_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Op        (Op),
      .Zero      (Zero),
`ifdef MULTICYCLE_MEM_WAIT_EN
      .MemReady  (mem_ready),
`endif
      .PCWrite   (PCWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .AdrSrc    (AdrSrc),
      .Branch    (Branch),
      .IllegalOp (IllegalOp),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ImmSrc    (ImmSrc),
      .State     (State)
   );

   always #5 clk = ~clk;

   function automatic bit is_legal(logic [6:0] op);
      return op inside {7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};
   endfunction

   // Phase list each instruction class walks through, named by state number.
   function automatic void phases(input logic [6:0] op, output int s[$]);
      case (op)
         7'd3:    s = '{0, 1, 2, 3, 4};
         7'd35:   s = '{0, 1, 2, 5};
         7'd51:   s = '{0, 1, 6, 8};
         7'd19:   s = '{0, 1, 7, 8};
         7'd111:  s = '{0, 1, 9, 8};
         7'd99:   s = '{0, 1, 10};
         default: s = '{0, 1};
      endcase
   endfunction

   function automatic logic [21:0] model(int st, logic [6:0] op, logic z, logic rdy);
      logic pcu = 0, irw = 0, rw = 0, mw = 0, adr = 0, br = 0, ill = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0, ao = 0;
      logic [2:0] imm;
      case (st)
         0:  begin irw = rdy; pcu = rdy; sb = 2'b10; rs = 2'b10; end
         1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(op); end
         2:  begin sa = 2'b10; sb = 2'b01; end
         3:  adr = 1'b1;
         4:  begin rs = 2'b01; rw = 1'b1; end
         5:  begin adr = 1'b1; mw = rdy; end
         6:  begin sa = 2'b10; ao = 2'b10; end
         7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
         8:  rw = 1'b1;
         9:  begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
         10: begin sa = 2'b10; ao = 2'b01; br = 1'b1; end
         default: ;
      endcase
      imm = (op == 7'd35) ? 3'b001 : (op == 7'd99) ? 3'b010 : (op == 7'd111) ? 3'b100 : 3'b000;
      return {4'(st), pcu | (br & z), irw, rw, mw, adr, br, ill, rs, sa, sb, ao, imm};
   endfunction

   task automatic cyc(int st, logic [6:0] op, int zmode, logic rdy, int step);
      exp_t e;
      Op        = op;
      Zero      = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      mem_ready = rdy;
      e.v    = model(st, op, Zero, rdy);
      e.op   = op;
      e.step = step;
      exp_q.push_back(e);
   endtask

   task automatic check_reset(int tag);
      n_cmp++;
      if ({State, PCWrite, IRWrite, RegWrite, MemWrite, IllegalOp} !== 9'd0) begin
         n_bad++;
         $display("FAIL reset_%0d act State=%0d strobes=%b req State=0 strobes=00000", tag, State,
                  {PCWrite, IRWrite, RegWrite, MemWrite, IllegalOp});
      end
   endtask

   // Entered and left at posedge+1; fwait<0 means random fetch wait count.
   task automatic run_instr(logic [6:0] op, int zmode, int fwait, bit abort);
      int s[$];
      int step = 0;
      phases(op, s);
      foreach (s[i]) begin
`ifdef MULTICYCLE_MEM_WAIT_EN
         if (s[i] inside {0, 3, 5}) begin
            int nw = (s[i] == 0 && fwait >= 0) ? fwait : $urandom_range(0, 2);
            repeat (nw) begin
               cyc(s[i], op, zmode, 1'b0, step++);
               @(posedge clk); #1;
            end
         end
`endif
         cyc(s[i], op, zmode, 1'b1, step++);
         if (abort && s[i] == 3) begin
            @(negedge clk); #2;
            rst_n = 1'b0;
            #1 check_reset(100 + step);
            @(posedge clk); #1;
            check_reset(200 + step);
            rst_n = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [21:0] act;
         e   = exp_q.pop_front();
         act = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Branch, IllegalOp,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};
         n_cmp++;
         if (act !== e.v) begin
            n_bad++;
            $display("FAIL op%0d_step%0d act=%h req=%h (State act %0d req %0d)", e.op, e.step,
                     act, e.v, act[21:18], e.v[21:18]);
         end
      end
   end

   initial begin
      logic [6:0] ops [6] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};
      logic [6:0] op;
      rst_n     = 1'b0;
      Op        = 7'd99;
      Zero      = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         Op = 7'($urandom_range(0, 127));
         #1 check_reset(i);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_instr(7'd3, 2, 3, 1'b0);
      run_instr(7'd35, 2, -1, 1'b0);
      run_instr(7'd99, 1, -1, 1'b0);
      run_instr(7'd99, 0, -1, 1'b0);
      run_instr(7'd0, 2, -1, 1'b0);
      run_instr(7'd51, 2, -1, 1'b0);
      run_instr(7'd19, 2, -1, 1'b0);
      run_instr(7'd111, 2, -1, 1'b0);
      run_instr(7'd3, 2, -1, 1'b1);
      run_instr(7'd35, 2, -1, 1'b0);
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            do op = 7'($urandom_range(0, 127)); while (is_legal(op));
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         run_instr(op, 2, -1, ($urandom_range(0, 9) == 0) && op == 7'd3);
      end
      @(negedge clk); #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain act=%0d pending req=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
